product_bcd_conv: RTL

Downstream consumer of the sequential 8x8 multiplier. Captures the 16-bit product when the multiplier's done flag rises. Converts it to 5 BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock. Holds the result and time-multiplexes the digits onto a scanned display bus.

---
 rtl/product_bcd_conv_pkg.sv | 14 +
 rtl/product_bcd_conv_bcd_add3.sv | 16 +
 rtl/product_bcd_conv.sv | 120 ++++++++++++
 3 files changed

// File: rtl/product_bcd_conv_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD display converter.
package product_bcd_conv_pkg;

    localparam int BCD_W      = 4;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/product_bcd_conv_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3
    import product_bcd_conv_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_W'(5)) begin
            dout = din + BCD_W'(3);
        end
    end

endmodule

// File: rtl/product_bcd_conv.sv
// Captures a binary product on the rising edge of load, converts it to BCD one
// bit per clock, holds the result and scans its digits onto a display bus.
module product_bcd_conv
    import product_bcd_conv_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DIGITS   = DEF_DIGITS,
    parameter int SCAN_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    reset_a,
    input  logic [WIDTH-1:0]        bin_in,
    input  logic                    load,
    output logic                    busy,
    output logic                    bcd_valid,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]       digit_sel,
    output logic [BCD_W-1:0]        digit_bcd
);

    localparam int BCD_TOT = BCD_W * DIGITS;
    localparam int SR_W    = BCD_TOT + WIDTH;
    localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    conv_state_t         state_q, state_d;
    logic                load_q;
    logic                start;
    logic [WIDTH-1:0]    bin_sr;
    logic [BCD_TOT-1:0]  bcd_sr;
    logic [BCD_TOT-1:0]  bcd_adj;
    logic [SR_W-1:0]     sr_shift;
    logic [CNT_W-1:0]    bit_cnt;
    logic                last_bit;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    scan_idx;

    assign start    = load & ~load_q;
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_sr[g*BCD_W +: BCD_W]),
            .dout (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // Adjusted digits and remaining binary bits move left as one register.
    assign sr_shift = {bcd_adj, bin_sr} << 1;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        bcd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                bcd_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            bit_cnt <= '0;
            bcd_out <= '0;
        end else if (state_q == IDLE && start) begin
            bin_sr  <= bin_in;
            bcd_sr  <= '0;
            bit_cnt <= '0;
        end else if (state_q == SHIFT) begin
            bcd_sr  <= sr_shift[SR_W-1 -: BCD_TOT];
            bin_sr  <= sr_shift[WIDTH-1:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) bcd_out <= sr_shift[SR_W-1 -: BCD_TOT];
        end
    end

    // Free-running scan; the outputs are registered from the index, so they
    // trail an index change (and a bcd_out change) by one clock.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            scan_cnt  <= '0;
            scan_idx  <= '0;
            digit_sel <= DIGITS'(1);
            digit_bcd <= '0;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            digit_sel <= DIGITS'(1) << scan_idx;
            digit_bcd <= bcd_out[BCD_W*scan_idx +: BCD_W];
        end
    end

endmodule
